// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button front end, run/pause/clear sequencing, lap capture and display mux for a 3-digit BCD stopwatch.
// Define STOPWATCH_CTRL_DEBOUNCE_EN to insert a DB_CNT-cycle debounce stage after each synchronizer.
module stopwatch_ctrl #(
    parameter int DB_CNT     = 1000000,
    parameter int CLR_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_ss,
    input  logic       btn_clr,
    input  logic       btn_lap,
    input  logic [3:0] d2_in,
    input  logic [3:0] d1_in,
    input  logic [3:0] d0_in,
    output logic       go,
    output logic       clr,
    output logic [3:0] disp2,
    output logic [3:0] disp1,
    output logic [3:0] disp0,
    output logic       running,
    output logic       lap_active,
    output logic       max_flag
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, CLEAR} state_t;
    state_t      r_state, w_next;
    logic [2:0]  r_s1, r_s2, r_prev, w_lvl, w_pulse;
    logic [3:0]  r_cnt;
    logic [11:0] r_lap, w_d;
    logic        w_ps, w_pc, w_pl, w_hit, w_lap_ok, w_cap, w_rel, w_go, w_clr, w_run;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_prev <= '0;
        end else begin
            r_s1   <= {btn_lap, btn_clr, btn_ss};
            r_s2   <= r_s1;
            r_prev <= w_lvl;
        end
    end
`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
    localparam int DW = $clog2(DB_CNT + 1);
    for (genvar i = 0; i < 3; i++) begin : g_db
        logic          r_lvl;
        logic [DW-1:0] r_db_cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_lvl    <= 1'b0;
                r_db_cnt <= '0;
            end else if (r_s2[i] == r_lvl) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DW'(DB_CNT - 1)) begin
                r_lvl    <= r_s2[i];
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
        assign w_lvl[i] = r_lvl;
    end
`else
    assign w_lvl = r_s2;
`endif
    assign w_pulse  = w_lvl & ~r_prev;
    assign {w_pl, w_pc, w_ps} = w_pulse;
    assign w_d      = {d2_in, d1_in, d0_in};
    // Auto-stop yields to clear and start/stop, but suppresses a same-cycle lap.
    assign w_hit    = (r_state == RUN) && !w_pc && !w_ps && (w_d == 12'h999);
    assign w_lap_ok = w_pl && !w_pc && !w_hit;
    assign w_cap    = w_lap_ok && (r_state == RUN) && !lap_active;
    assign w_rel    = w_lap_ok && ((r_state == RUN) || (r_state == PAUSE)) && lap_active;
    always_comb begin
        w_next = r_state;
        if (w_pc) w_next = CLEAR;
        else begin
            case (r_state)
                IDLE:    w_next = w_ps ? RUN : IDLE;
                RUN:     w_next = (w_ps || w_hit) ? PAUSE : RUN;
                PAUSE:   w_next = (w_ps && !max_flag) ? RUN : PAUSE;
                default: w_next = (r_cnt == 4'd0) ? IDLE : CLEAR;
            endcase
        end
    end
    always_comb begin
        w_go  = (w_next == RUN);
        w_run = (w_next == RUN);
        w_clr = (w_next == CLEAR);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            go      <= 1'b0;
            clr     <= 1'b0;
            running <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_pc ? 4'(CLR_CYCLES - 1) : (r_state == CLEAR && r_cnt != 4'd0) ? r_cnt - 4'd1 : r_cnt;
            go      <= w_go;
            clr     <= w_clr;
            running <= w_run;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lap      <= '0;
            lap_active <= 1'b0;
            max_flag   <= 1'b0;
        end else if (w_pc) begin
            lap_active <= 1'b0;
            max_flag   <= 1'b0;
        end else begin
            if (w_hit) max_flag <= 1'b1;
            if (w_cap) begin
                r_lap      <= w_d;
                lap_active <= 1'b1;
            end else if (w_rel) lap_active <= 1'b0;
        end
    end
    assign {disp2, disp1, disp0} = lap_active ? r_lap : w_d;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed stimulus with a per-cycle reference model of the stopwatch front panel.
module tb_stopwatch_ctrl;
    logic       clk = 1'b0, rst_n = 1'b0, btn_ss = 1'b0, btn_clr = 1'b0, btn_lap = 1'b0;
    logic [3:0] d2_in = '0, d1_in = '0, d0_in = '0;
    logic       go, clr, running, lap_active, max_flag;
    logic [3:0] disp2, disp1, disp0;
    int         checks = 0, errors = 0;
    bit         model_on = 1'b1;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.DB_CNT(8), .CLR_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .btn_ss(btn_ss), .btn_clr(btn_clr), .btn_lap(btn_lap),
        .d2_in(d2_in), .d1_in(d1_in), .d0_in(d0_in), .go(go), .clr(clr),
        .disp2(disp2), .disp1(disp1), .disp0(disp0), .running(running),
        .lap_active(lap_active), .max_flag(max_flag)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: mode 0 idle, 1 run, 2 pause, 3 clearing; clr_left counts clr-high cycles still owed.
    int       mode = 0, clr_left = 0, lap_val = 0, rec_val = 0, shown;
    bit       lap_on = 0, maxed = 0, rec_rst = 0, hit;
    bit [2:0] h1 = 0, h2 = 0, h3 = 0, rec_btn = 0, p;

    always @(negedge clk) begin
        if (!rst_n) begin
            mode = 0; clr_left = 0; lap_on = 0; maxed = 0; lap_val = 0;
            h1 = 0; h2 = 0; h3 = 0;
        end else if (rec_rst) begin
            p = h2 & ~h3;
            h3 = h2; h2 = h1; h1 = rec_btn;
            if (p[1]) begin
                mode = 3; clr_left = 2; lap_on = 0; maxed = 0;
            end else begin
                hit = (mode == 1) && !p[0] && (rec_val == 999);
                if (p[2] && !hit && (mode == 1 || mode == 2)) begin
                    if (lap_on) lap_on = 0;
                    else if (mode == 1) begin lap_on = 1; lap_val = rec_val; end
                end
                if (mode == 3) begin
                    clr_left--;
                    if (clr_left == 0) mode = 0;
                end else if (mode == 0) begin
                    if (p[0]) mode = 1;
                end else if (mode == 1) begin
                    if (p[0] || hit) mode = 2;
                    if (hit) maxed = 1;
                end else if (p[0] && !maxed) mode = 1;
            end
        end
        if (model_on) begin
            shown = lap_on ? lap_val : d2_in * 100 + d1_in * 10 + d0_in;
            chk("go", 16'(go), 16'(mode == 1));
            chk("running", 16'(running), 16'(mode == 1));
            chk("clr", 16'(clr), 16'(mode == 3));
            chk("lap_active", 16'(lap_active), 16'(lap_on));
            chk("max_flag", 16'(max_flag), 16'(maxed));
            chk("disp", 16'({disp2, disp1, disp0}),
                16'({4'(shown / 100), 4'((shown / 10) % 10), 4'(shown % 10)}));
        end
        rec_rst = rst_n;
        rec_btn = {btn_lap, btn_clr, btn_ss};
        rec_val = d2_in * 100 + d1_in * 10 + d0_in;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic press_ss();
        btn_ss = 1'b1; cyc(1); btn_ss = 1'b0; cyc(4);
    endtask

    initial begin
        cyc(3);
        rst_n = 1'b1;
        chk("reset_go", 16'(go), 16'd0);
        chk("reset_clr", 16'(clr), 16'd0);
        chk("reset_max", 16'(max_flag), 16'd0);
        cyc(2);
`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
        model_on = 1'b0;
        btn_ss = 1'b1; cyc(5); btn_ss = 1'b0; cyc(20);
        chk("db_glitch_running", 16'(running), 16'd0);
        btn_ss = 1'b1; cyc(10);
        chk("db_press_early", 16'(running), 16'd0);
        cyc(1);
        chk("db_press_run", 16'(running), 16'd1);
        chk("db_press_go", 16'(go), 16'd1);
        cyc(1); btn_ss = 1'b0; cyc(20);
        chk("db_release_hold", 16'(running), 16'd1);
`else
        btn_ss = 1'b1; cyc(2);
        chk("ss_latency_go0", 16'(go), 16'd0);
        cyc(1);
        chk("ss_latency_go1", 16'(go), 16'd1);
        chk("ss_latency_run", 16'(running), 16'd1);
        cyc(3); btn_ss = 1'b0; cyc(3);
        chk("ss_held_once", 16'(running), 16'd1);
        {d2_in, d1_in, d0_in} = 12'h347; cyc(1);
        btn_lap = 1'b1; cyc(1); btn_lap = 1'b0; cyc(4);
        chk("lap_on", 16'(lap_active), 16'd1);
        {d2_in, d1_in, d0_in} = 12'h502; cyc(1);
        chk("lap_frozen", 16'({disp2, disp1, disp0}), 16'h347);
        btn_lap = 1'b1; cyc(1); btn_lap = 1'b0; cyc(4);
        chk("lap_off_disp", 16'({disp2, disp1, disp0}), 16'h502);
        press_ss();
        chk("pause_go", 16'(go), 16'd0);
        press_ss();
        chk("resume_go", 16'(go), 16'd1);
        btn_clr = 1'b1; cyc(2);
        chk("clr_pre", 16'(clr), 16'd0);
        cyc(1);
        chk("clr_c1", 16'(clr), 16'd1);
        chk("clr_go", 16'(go), 16'd0);
        cyc(1);
        chk("clr_c2", 16'(clr), 16'd1);
        cyc(1);
        chk("clr_done", 16'(clr), 16'd0);
        btn_clr = 1'b0; cyc(3);
        press_ss();
        {d2_in, d1_in, d0_in} = 12'h998; cyc(2);
        {d2_in, d1_in, d0_in} = 12'h999; cyc(1);
        chk("max_go", 16'(go), 16'd0);
        chk("max_flag", 16'(max_flag), 16'd1);
        press_ss();
        chk("max_ss_ignored", 16'(running), 16'd0);
        btn_clr = 1'b1; cyc(1); btn_clr = 1'b0; cyc(5);
        chk("max_cleared", 16'(max_flag), 16'd0);
        {d2_in, d1_in, d0_in} = 12'h000;
        btn_ss = 1'b1; btn_clr = 1'b1; cyc(1); btn_ss = 1'b0; btn_clr = 1'b0; cyc(2);
        chk("ss_clr_clear", 16'(clr), 16'd1);
        chk("ss_clr_norun", 16'(running), 16'd0);
        cyc(4);
        btn_lap = 1'b1; cyc(1); btn_lap = 1'b0; cyc(4);
        chk("idle_lap", 16'(lap_active), 16'd0);
        press_ss();
        {d2_in, d1_in, d0_in} = 12'h123; cyc(1);
        btn_ss = 1'b1; btn_lap = 1'b1; cyc(1); btn_ss = 1'b0; btn_lap = 1'b0; cyc(4);
        chk("ss_lap_pause", 16'(running), 16'd0);
        chk("ss_lap_cap", 16'({disp2, disp1, disp0}), 16'h123);
        {d2_in, d1_in, d0_in} = 12'h456;
        btn_lap = 1'b1; cyc(1); btn_lap = 1'b0; cyc(4);
        chk("pause_lap_off", 16'(lap_active), 16'd0);
        btn_clr = 1'b1; cyc(1); btn_clr = 1'b0; cyc(1); btn_clr = 1'b1; cyc(1); btn_clr = 1'b0; cyc(8);
        press_ss(); cyc(2);
        rst_n = 1'b0; #1;
        chk("rst_run_go", 16'(go), 16'd0);
        chk("rst_run_clr", 16'(clr), 16'd0);
        cyc(1); rst_n = 1'b1; cyc(3);
        btn_clr = 1'b1; cyc(3);
        chk("rst_clr_pre", 16'(clr), 16'd1);
        rst_n = 1'b0; #1;
        chk("rst_clr_clr", 16'(clr), 16'd0);
        cyc(1); rst_n = 1'b1; btn_clr = 1'b0; cyc(5);
        chk("rst_clr_idle", 16'(running), 16'd0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
